// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers VGA timing from incoming hsync/vsync. It measures the line length
// and frame length, locks after LOCK_FRAMES consecutive good frames, and then
// regenerates the active-video flag and pixel coordinates.
//
// Optional feature: define SYNC_WIDTH_CHECK_EN to also check the sync pulse
// widths (hsync high for H_SYNC clocks, vsync high for V_SYNC lines). A wrong
// width counts as a line error. Without the macro the width logic is absent.
//
// Ports:
//   clk          pixel clock (single clock domain)
//   clr_n        asynchronous active-low reset
//   hsync_in     active-high horizontal sync, synchronous to clk
//   vsync_in     active-high vertical sync, synchronous to clk
//   PixelX/Y     recovered active-pixel coordinates (0 outside the window)
//   vidon        recovered active-video flag
//   locked       timing lock indication
//   sync_err     one-cycle pulse when the timing breaks while locked
//   h_period     last measured line length in clocks
//   v_total      last measured frame length in lines
//   frame_start  one-cycle pulse on each vsync rising edge
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned H_BP        = 144,
    parameter int unsigned H_FP        = 784,
    parameter int unsigned V_BP        = 35,
    parameter int unsigned V_FP        = 515,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] PixelX,
    output logic [10:0] PixelY,
    output logic        vidon,
    output logic        locked,
    output logic        sync_err,
    output logic [10:0] h_period,
    output logic [10:0] v_total,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    localparam logic [10:0] CNT_MAX = '1;

    // Elaboration-time sanity checks on the timing parameters.
    if (H_SYNC == 0 || H_SYNC >= H_TOTAL || V_SYNC == 0 || V_SYNC >= V_TOTAL) begin : g_bad_sync
        $error("vga_sync_decoder: sync width must be nonzero and shorter than the period");
    end
    if (H_BP >= H_FP || V_BP >= V_FP || LOCK_FRAMES == 0 || LOCK_FRAMES > 255) begin : g_bad_window
        $error("vga_sync_decoder: bad active window or LOCK_FRAMES");
    end

    logic        hs_d;
    logic        vs_d;
    logic        hs_rise;
    logic        vs_rise;
    logic [10:0] h_count;
    logic [10:0] v_count;
    logic [11:0] h_meas;
    logic [11:0] v_meas;
    logic        width_err;
    logic        line_err;
    logic        frame_err;
    logic        vid_win;
    state_t      state;
    logic [7:0]  good_cnt;

    always_comb begin
        hs_rise = hsync_in & ~hs_d;
        vs_rise = vsync_in & ~vs_d;
        // Measurements are one bit wider so a saturated counter can never
        // alias to a legal period.
        h_meas  = {1'b0, h_count} + 12'd1;
        v_meas  = {1'b0, v_count} + {11'd0, hs_rise};
        line_err  = (hs_rise && (h_meas != 12'(H_TOTAL))) || (h_count == CNT_MAX) || width_err;
        frame_err = (vs_rise && (v_meas != 12'(V_TOTAL))) || (v_count == CNT_MAX);
        vid_win   = (state == LOCKED) &&
                    (h_count > 11'(H_BP)) && (h_count < 11'(H_FP)) &&
                    (v_count > 11'(V_BP)) && (v_count < 11'(V_FP));
    end

`ifdef SYNC_WIDTH_CHECK_EN
    logic        hs_fall;
    logic        vs_fall;
    logic [10:0] hw_cnt;   // hsync high samples since the last rise
    logic [10:0] vw_cnt;   // hsync rises seen while vsync is high

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hw_cnt <= '0;
            vw_cnt <= '0;
        end else begin
            if (hs_rise)
                hw_cnt <= 11'd1;
            else if (hsync_in && (hw_cnt != CNT_MAX))
                hw_cnt <= hw_cnt + 11'd1;

            if (vs_rise)
                vw_cnt <= {10'd0, hs_rise};
            else if (vsync_in && hs_rise && (vw_cnt != CNT_MAX))
                vw_cnt <= vw_cnt + 11'd1;
        end
    end

    always_comb begin
        hs_fall   = ~hsync_in & hs_d;
        vs_fall   = ~vsync_in & vs_d;
        width_err = (hs_fall && (hw_cnt != 11'(H_SYNC))) ||
                    (vs_fall && (vw_cnt != 11'(V_SYNC)));
    end
`else
    assign width_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            h_period    <= '0;
            v_total     <= '0;
            PixelX      <= '0;
            PixelY      <= '0;
            vidon       <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
            good_cnt    <= '0;
            state       <= SEARCH;
        end else begin
            hs_d <= hsync_in;
            vs_d <= vsync_in;

            if (hs_rise)
                h_count <= '0;
            else if (h_count != CNT_MAX)
                h_count <= h_count + 11'd1;

            if (hs_rise)
                h_period <= h_meas[10:0];

            // A vsync rise wins over a coincident hsync rise: the line it
            // starts is line 0, but it is still counted into v_total.
            if (vs_rise) begin
                v_count <= '0;
                v_total <= v_meas[10:0];
            end else if (hs_rise && (v_count != CNT_MAX)) begin
                v_count <= v_count + 11'd1;
            end

            frame_start <= vs_rise;
            vidon       <= vid_win;
            PixelX      <= vid_win ? (h_count - 11'(H_BP)) : '0;
            PixelY      <= vid_win ? (v_count - 11'(V_BP)) : '0;
            sync_err    <= 1'b0;

            case (state)
                SEARCH: begin
                    if (vs_rise) begin
                        state    <= VERIFY;
                        good_cnt <= '0;
                    end
                end
                VERIFY: begin
                    if (line_err || frame_err) begin
                        state <= SEARCH;
                    end else if (vs_rise) begin
                        good_cnt <= good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == 8'(LOCK_FRAMES)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (line_err || frame_err) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Bench for vga_sync_decoder with a reduced timing (64 clocks x 24 lines) so
// that many frames fit in a short run. A behavioural model tracks timestamps
// of sync edges and derives every output from them; a compare process checks
// all outputs on every falling clock edge, and directed checkpoints pin
// hand-computed values. Compile with +define+SYNC_WIDTH_CHECK_EN to exercise
// the pulse-width check.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int HT  = 64;
    localparam int HS  = 8;
    localparam int VT  = 24;
    localparam int VS  = 2;
    localparam int HBP = 12;
    localparam int HFP = 60;
    localparam int VBP = 4;
    localparam int VFP = 22;
    localparam int LF  = 2;

    logic        clk      = 1'b0;
    logic        clr_n    = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [10:0] PixelX;
    logic [10:0] PixelY;
    logic        vidon;
    logic        locked;
    logic        sync_err;
    logic [10:0] h_period;
    logic [10:0] v_total;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_TOTAL    (HT),
        .H_SYNC     (HS),
        .V_TOTAL    (VT),
        .V_SYNC     (VS),
        .H_BP       (HBP),
        .H_FP       (HFP),
        .V_BP       (VBP),
        .V_FP       (VFP),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .PixelX     (PixelX),
        .PixelY     (PixelY),
        .vidon      (vidon),
        .locked     (locked),
        .sync_err   (sync_err),
        .h_period   (h_period),
        .v_total    (v_total),
        .frame_start(frame_start)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is counted in clock edges since start; h_count is "edges since the
    // last hsync rise", v_count is "hsync rises since the last vsync rise".
    int m_e        = 0;   // edges stepped
    int m_anchor   = 0;   // edge of last hsync rise (or reset)
    int m_hr       = 0;   // total hsync rises
    int m_hr_vr    = 0;   // m_hr just after last vsync rise
    int m_hr_vrpre = 0;   // m_hr just before last vsync rise
    int m_phase    = -1;  // -1 searching, 0..LF-1 good frames seen, LF locked
    bit m_ph       = 1'b0;
    bit m_pv       = 1'b0;

    int e_px = 0, e_py = 0, e_hper = 0, e_vtot = 0;
    bit e_vid = 1'b0, e_lock = 1'b0, e_err = 1'b0, e_fs = 1'b0;

    task automatic model_reset();
        m_anchor   = m_e;
        m_hr_vr    = m_hr;
        m_hr_vrpre = m_hr;
        m_phase    = -1;
        m_ph       = 1'b0;
        m_pv       = 1'b0;
        e_px = 0; e_py = 0; e_hper = 0; e_vtot = 0;
        e_vid = 1'b0; e_lock = 1'b0; e_err = 1'b0; e_fs = 1'b0;
    endtask

    task automatic model_step(input bit h, input bit v);
        int hc, vc, per, vt;
        bit hr, vr, hf, vf, lerr, ferr, vid;
        m_e++;
        hc = m_e - 1 - m_anchor;
        if (hc > 2047) hc = 2047;
        vc = m_hr - m_hr_vr;
        if (vc > 2047) vc = 2047;
        hr = h && !m_ph;
        vr = v && !m_pv;
        hf = !h && m_ph;
        vf = !v && m_pv;

        vid   = (m_phase == LF) && hc > HBP && hc < HFP && vc > VBP && vc < VFP;
        e_vid = vid;
        e_px  = vid ? hc - HBP : 0;
        e_py  = vid ? vc - VBP : 0;
        e_fs  = vr;

        lerr = (hc == 2047);
        ferr = (vc == 2047);
        if (hr) begin
            per    = hc + 1;
            e_hper = per % 2048;
            if (per != HT) lerr = 1'b1;
        end
`ifdef SYNC_WIDTH_CHECK_EN
        if (hf && (m_e - m_anchor) != HS) lerr = 1'b1;
        if (vf && (m_hr - m_hr_vrpre) != VS) lerr = 1'b1;
`else
        if (hf || vf) begin end
`endif
        if (vr) begin
            vt     = vc + (hr ? 1 : 0);
            e_vtot = vt % 2048;
            if (vt != VT) ferr = 1'b1;
            m_hr_vrpre = m_hr;
        end
        if (hr) begin
            m_hr++;
            m_anchor = m_e;
        end
        if (vr) m_hr_vr = m_hr;

        e_err = 1'b0;
        if (m_phase < 0) begin
            if (vr) m_phase = 0;
        end else if (m_phase < LF) begin
            if (lerr || ferr) m_phase = -1;
            else if (vr) m_phase++;
        end else if (lerr || ferr) begin
            m_phase = -1;
            e_err   = 1'b1;
        end
        e_lock = (m_phase == LF);
        m_ph = h;
        m_pv = v;
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) model_reset();
        else        model_step(hsync_in, vsync_in);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_vidon",       vidon,       e_vid);
            check("cmp_PixelX",      PixelX,      e_px);
            check("cmp_PixelY",      PixelY,      e_py);
            check("cmp_locked",      locked,      e_lock);
            check("cmp_sync_err",    sync_err,    e_err);
            check("cmp_frame_start", frame_start, e_fs);
            check("cmp_h_period",    h_period,    e_hper);
            check("cmp_v_total",     v_total,     e_vtot);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit h, input bit v);
        hsync_in = h;
        vsync_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int len, input int hw, input bit vs, input int first);
        for (int i = first; i < len; i++) step(bit'(i < hw), vs);
    endtask

    task automatic drive_lines(input int first, input int last);
        for (int l = first; l <= last; l++) drive_line(HT, HS, bit'(l < VS), 0);
    endtask

    int pulses;
    int pulse_at;

    initial begin
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #1;
        check("rst_locked",   locked,   0);
        check("rst_h_period", h_period, 0);
        check("rst_v_total",  v_total,  0);
        check("rst_vidon",    vidon,    0);
        clr_n = 1'b1;

        // Nominal frames: lock on the 3rd vsync rise.
        drive_lines(0, VT - 1);
        drive_lines(0, VT - 1);
        check("prelock_locked", locked, 0);
        step(1'b1, 1'b1);
        check("lock3_locked",      locked,      1);
        check("lock3_frame_start", frame_start, 1);
        check("lock3_v_total",     v_total,     VT);
        check("lock3_h_period",    h_period,    HT);
        drive_line(HT, HS, 1'b1, 1);
        check("fs_pulse_end", frame_start, 0);

        // Active window corners.
        drive_lines(1, VBP);
        drive_line(HBP + 2, HS, 1'b0, 0);
        check("win_left_excl_vidon", vidon, 0);
        step(1'b0, 1'b0);
        check("win_first_vidon",  vidon,  1);
        check("win_first_PixelX", PixelX, 1);
        check("win_first_PixelY", PixelY, 1);
        drive_line(HT, HS, 1'b0, HBP + 3);
        drive_line(HFP + 1, HS, 1'b0, 0);
        check("win_last_vidon",  vidon,  1);
        check("win_last_PixelX", PixelX, HFP - 1 - HBP);
        check("win_last_PixelY", PixelY, 2);
        step(1'b0, 1'b0);
        check("win_right_excl_vidon",  vidon,  0);
        check("win_right_excl_PixelX", PixelX, 0);
        drive_line(HT, HS, 1'b0, HFP + 2);
        drive_lines(VBP + 3, VT - 1);

        // One over-long line while locked.
        drive_lines(0, 9);
        drive_line(HT + 1, HS, 1'b0, 0);
        check("long_line_still_locked", locked, 1);
        step(1'b1, 1'b0);
        check("long_line_sync_err", sync_err, 1);
        check("long_line_locked",   locked,   0);
        check("long_line_h_period", h_period, HT + 1);
        step(1'b1, 1'b0);
        check("long_line_err_single", sync_err, 0);
        drive_line(HT, HS, 1'b0, 2);
        drive_lines(12, VT - 1);
        drive_lines(0, VT - 1);
        drive_lines(0, VT - 1);
        check("relock_pre_locked", locked, 0);
        step(1'b1, 1'b1);
        check("relock_locked", locked, 1);
        drive_line(HT, HS, 1'b1, 1);
        drive_lines(1, 5);

        // Lost hsync: h_count saturates and the lock drops once.
        pulses   = 0;
        pulse_at = 0;
        for (int j = 1; j <= 2100; j++) begin
            step(1'b0, 1'b0);
            if (sync_err) begin
                pulses++;
                pulse_at = j;
            end
        end
        check("lost_h_pulses",   pulses,   1);
        check("lost_h_pulse_at", pulse_at, 2049 - HT);
        check("lost_h_locked",   locked,   0);

        // Relock, then reset mid-line inside the active window.
        drive_lines(0, VT - 1);
        drive_lines(0, VT - 1);
        step(1'b1, 1'b1);
        check("relock2_locked", locked, 1);
        drive_line(HT, HS, 1'b1, 1);
        drive_lines(1, 9);
        drive_line(30, HS, 1'b0, 0);
        check("prereset_vidon", vidon, 1);
        #2 clr_n = 1'b0;
        #1;
        check("midrst_locked",      locked,      0);
        check("midrst_vidon",       vidon,       0);
        check("midrst_PixelX",      PixelX,      0);
        check("midrst_PixelY",      PixelY,      0);
        check("midrst_h_period",    h_period,    0);
        check("midrst_v_total",     v_total,     0);
        check("midrst_sync_err",    sync_err,    0);
        check("midrst_frame_start", frame_start, 0);
        repeat (3) step(1'b0, 1'b0);
        clr_n = 1'b1;
        drive_lines(0, VT - 1);
        drive_lines(0, VT - 1);
        check("postrst_pre_locked", locked, 0);
        step(1'b1, 1'b1);
        check("postrst_locked", locked, 1);
        drive_line(HT, HS, 1'b1, 1);
        drive_lines(1, 7);

        // Short hsync pulse while locked.
        drive_line(HS, HS - 1, 1'b0, 0);
`ifdef SYNC_WIDTH_CHECK_EN
        check("short_hs_sync_err", sync_err, 1);
        check("short_hs_locked",   locked,   0);
`else
        check("short_hs_sync_err", sync_err, 0);
        check("short_hs_locked",   locked,   1);
`endif
        drive_line(HT, HS - 1, 1'b0, HS);
        drive_lines(9, VT - 1);
        drive_lines(0, VT - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
